// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant sequencer with hold timeout and one-cycle guard gap between owners.
module rr_grant_ctrl #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   gnt_nx;
    logic [IW-1:0]  id_nx, ptr, ptr_nx, sel, id_inc;
    logic [HW-1:0]  hold_cnt, hold_nx;
    logic           busy_nx, timeout_nx, release_now, owner_done;

    // First requester at or after ptr, wrapping modulo N.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] s;
        logic          f;
        int            k;
        s = '0;
        f = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(p) + i) % N;
            if (!f && r[k]) begin
                s = IW'(k);
                f = 1'b1;
            end
        end
        return s;
    endfunction

    assign sel         = pick(req, ptr);
    assign id_inc      = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    assign owner_done  = done[gnt_id];
    assign release_now = owner_done || (hold_cnt == HW'(MAX_HOLD - 1));

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        id_nx      = gnt_id;
        ptr_nx     = ptr;
        hold_nx    = hold_cnt;
        busy_nx    = busy;
        timeout_nx = 1'b0;
        case (state)
            IDLE: if (|req) begin
                state_nx = GRANT;
                gnt_nx   = N'(1) << sel;
                id_nx    = sel;
                busy_nx  = 1'b1;
                hold_nx  = '0;
            end
            GRANT: if (release_now) begin
                // done beats an expiring hold, so timeout only fires without done
                state_nx   = GAP;
                gnt_nx     = '0;
                busy_nx    = 1'b0;
                ptr_nx     = id_inc;
                timeout_nx = !owner_done;
            end else begin
                hold_nx = hold_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            gnt_id   <= id_nx;
            busy     <= busy_nx;
            timeout  <= timeout_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
        end
    end
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed and randomized checks of rr_grant_ctrl against an owner/age reference model.
module tb_rr_grant_ctrl;
    localparam int N        = 2;
    localparam int MAX_HOLD = 8;
    localparam int IW       = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req, done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy, timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource, for how many cycles, and whether a gap is pending.
    int m_owner, m_age, m_ptr, m_last;
    bit m_gap, m_to;

    rr_grant_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_ptr   = 0;
        m_last  = 0;
        m_gap   = 0;
        m_to    = 0;
    endtask

    task automatic model_edge();
        bit d;
        m_to = 0;
        if (m_owner >= 0) begin
            d = done[m_owner];
            m_age++;
            if (d || m_age == MAX_HOLD) begin
                m_to    = !d;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (m_owner < 0 && req[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_last  = m_owner;
                    m_age   = 0;
                end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e;
        e = '0;
        if (m_owner >= 0) e[m_owner] = 1'b1;
        chk("gnt", 32'(gnt), 32'(e));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("gnt_id", 32'(gnt_id), 32'(m_last));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("busy_or_gnt", 32'(busy), 32'(|gnt));
        chk("timeout_no_gnt", 32'(timeout && (|gnt)), 32'd0);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b1;
        req   = '0;
        done  = '0;
        #2;
        do_reset();

        // single requester: release on 3rd grant cycle, regrant two edges later
        step(2'b01, 2'b00);
        chk("t1_first_gnt", 32'(gnt), 32'h1);
        step(2'b01, 2'b00);
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        chk("t1_release", 32'(gnt), 32'h0);
        step(2'b01, 2'b00);
        chk("t1_gap", 32'(gnt), 32'h0);
        step(2'b01, 2'b00);
        chk("t1_regrant", 32'(gnt), 32'h1);

        // contention: alternating owners
        do_reset();
        for (int g = 0; g < 4; g++) begin
            cnt = 0;
            while (!busy && cnt < 5) begin
                step(2'b11, 2'b00);
                cnt++;
            end
            chk("rr_grant_seen", 32'(busy), 32'd1);
            chk("rr_id", 32'(gnt_id), 32'(g % 2));
            step(2'b11, gnt);
        end

        // timeout: exactly MAX_HOLD grant cycles, then pointer moves to 0
        do_reset();
        step(2'b10, 2'b00);
        cnt = 0;
        for (int i = 0; i < 20 && gnt == 2'b10; i++) begin
            cnt++;
            step(2'b10, 2'b00);
        end
        chk("to_len", 32'(cnt), 32'(MAX_HOLD));
        chk("to_pulse", 32'(timeout), 32'd1);
        step(2'b11, 2'b00);
        chk("to_pulse_end", 32'(timeout), 32'd0);
        step(2'b11, 2'b00);
        chk("to_ptr_next", 32'(gnt), 32'h1);

        // done coincides with hold expiry
        do_reset();
        step(2'b01, 2'b00);
        repeat (MAX_HOLD - 1) step(2'b01, 2'b00);
        chk("both_gnt_before", 32'(gnt), 32'h1);
        step(2'b01, 2'b01);
        chk("both_gnt_clear", 32'(gnt), 32'h0);
        chk("both_no_timeout", 32'(timeout), 32'd0);

        // foreign done and dropped req are ignored
        do_reset();
        step(2'b01, 2'b00);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step(2'b00, 2'b10);
            if (gnt != 2'b01) break;
            cnt++;
        end
        chk("foreign_len", 32'(cnt), 32'(MAX_HOLD));
        chk("foreign_timeout", 32'(timeout), 32'd1);

        // asynchronous reset while requester 1 owns the resource
        do_reset();
        step(2'b10, 2'b00);
        step(2'b10, 2'b00);
        chk("mid_gnt_pre", 32'(gnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_timeout", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b11, 2'b00);
        chk("post_reset_owner", 32'(gnt), 32'h1);

        // randomized traffic, with an occasional reset
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 197 == 196) do_reset();
            step(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
